// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: FSM states, host command
// codes, default HALT opcode and a ceil-log2 helper for counter sizing.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear outranks increment so an abort in an enabled cycle leaves zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Debug sequencer owning the global pipeline enable: run / single-step / abort
// from the host, HALT detection with a fixed drain, and an enabled-cycle count.
module pipeline_run_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int                  NB_INSTR   = 32,
  parameter int                  NB_CYCLE   = 32,
  parameter int                  N_DRAIN    = 4,
  parameter logic [NB_INSTR-1:0] HALT_INSTR = NB_INSTR'(HALT_INSTR_DEFAULT)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic [NB_INSTR-1:0] i_ir,
  output logic                o_valid,
  output logic                o_running,
  output logic                o_halted,
  output logic                o_step_done,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam int DRAIN_BITS = clogb2(N_DRAIN + 1);
  localparam int DRAIN_W    = (DRAIN_BITS < 1) ? 1 : DRAIN_BITS;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(N_DRAIN);

  state_t              state_q;
  state_t              state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic [DRAIN_W-1:0]  drain_cnt_d;
  logic                step_done_q;
  logic                step_done_d;

  logic                cmd_ready;
  logic                cmd_accept;
  logic                abort_accept;
  logic                halt_hit;
  logic                count_clear;
  logic                pipe_enable;

  assign cmd_ready    = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign cmd_accept   = i_cmd_valid && cmd_ready;
  assign abort_accept = cmd_accept && (i_cmd == CMD_ABORT);
  assign halt_hit     = (i_ir == HALT_INSTR);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    step_done_d = 1'b0;
    count_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          case (i_cmd)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  state_d = ST_STEP;
            CMD_ABORT: count_clear = 1'b1;
            default:   ;
          endcase
        end
      end
      ST_RUN: begin
        // Abort beats a HALT seen in the same cycle.
        if (abort_accept) begin
          state_d     = ST_IDLE;
          count_clear = 1'b1;
        end else if (halt_hit) begin
          if (N_DRAIN == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          if (N_DRAIN == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end else begin
          state_d     = ST_IDLE;
          step_done_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        if (drain_cnt_d == '0) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (abort_accept) begin
          state_d     = ST_IDLE;
          count_clear = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      step_done_q <= step_done_d;
    end
  end

  // Enable is a pure decode of the state register so it cannot glitch.
  assign pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

  sat_counter #(
    .WIDTH (NB_CYCLE)
  ) u_cycle_counter (
    .clk   (i_clock),
    .srst  (i_reset),
    .en    (pipe_enable),
    .clr   (count_clear),
    .count (o_cycle_count)
  );

  assign o_valid     = pipe_enable;
  assign o_cmd_ready = cmd_ready;
  assign o_running   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_halted    = (state_q == ST_HALTED);
  assign o_step_done = step_done_q;

endmodule
